// File: rtl/pipe_skid_stage_if.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage_if
// Handshake bundle for one pipeline skid stage.
//   in_valid / in_ready / in_data     : upstream valid/ready channel
//   out_valid / out_ready / out_data  : downstream valid/ready channel
//   flush                             : synchronous squash of held beats
//   stall_count                       : saturating backpressure counter
// modport slave  : view of the stage itself
// modport master : view of the logic driving and consuming the stage
// ---------------------------------------------------------------------------
interface pipe_skid_stage_if #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 flush;
  logic [CNT_WIDTH-1:0] stall_count;

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, stall_count
  );

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, stall_count
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
// Two-entry pipeline register (main + skid) that fully decouples upstream
// ready from downstream ready while sustaining one beat per cycle.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : pipe_skid_stage_if.slave handshake bundle (see interface file)
// Parameters:
//   WIDTH       : payload width
//   RESET_VALUE : bubble payload shown on out_data whenever out_valid=0
//   CNT_WIDTH   : width of the saturating stall counter
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_WIDTH   = 16
) (
  input logic              clock,
  input logic              reset,
  pipe_skid_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     main_q, main_d;
  logic [WIDTH-1:0]     skid_q, skid_d;
  logic                 in_ready_q;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  logic out_valid;
  logic accept;
  logic take;

  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid & in_ready_q;
  assign take      = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = BUSY;
          main_d  = bus.in_data;
        end
      end
      BUSY: begin
        if (accept && take) begin
          main_d = bus.in_data;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = bus.in_data;
        end else if (take) begin
          // Reload the bubble so out_data shows RESET_VALUE while empty.
          state_d = EMPTY;
          main_d  = RESET_VALUE;
        end
      end
      FULL: begin
        // in_ready is low here, so no new beat can arrive.
        if (take) begin
          state_d = BUSY;
          main_d  = skid_q;
          skid_d  = RESET_VALUE;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = RESET_VALUE;
        skid_d  = RESET_VALUE;
      end
    endcase

    // Redirect squash wins over everything, including a same-cycle accept.
    if (bus.flush) begin
      state_d = EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end
  end

  // Backpressure counter keeps running through a flush and sticks at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !bus.out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= RESET_VALUE;
      skid_q     <= RESET_VALUE;
      in_ready_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      // Registered from next state, so no path from out_ready to in_ready.
      in_ready_q <= (state_d != FULL);
      stall_q    <= stall_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = main_q;
  assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int               W  = 16;
  localparam logic [W-1:0]     RV = 16'hBEEF;

  logic clock;
  logic reset;

  int total = 0;
  int bad   = 0;
  int exp_stall = 0;

  pipe_skid_stage_if #(.WIDTH(W), .CNT_WIDTH(16)) bus ();
  pipe_skid_stage_if #(.WIDTH(W), .CNT_WIDTH(4))  bus4 ();

  pipe_skid_stage #(.WIDTH(W), .RESET_VALUE(RV), .CNT_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  pipe_skid_stage #(.WIDTH(W), .RESET_VALUE(RV), .CNT_WIDTH(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4.slave)
  );

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_data   = bus.in_data;
  assign bus4.out_ready = bus.out_ready;
  assign bus4.flush     = bus.flush;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] d,
                         input logic rdy, input int st);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(d));
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(rdy));
    chk({tag, ".stall"},     32'(bus.stall_count), 32'(st));
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset state
    tick();
    tick();
    chk_out("rst", 1'b0, RV, 1'b0, 0);
    chk("rst.stall4", 32'(bus4.stall_count), 32'h0);
    reset = 1'b0;
    #1;
    chk("rel.in_ready_low", 32'(bus.in_ready), 32'h0);
    tick();
    chk("rel.in_ready_high", 32'(bus.in_ready), 32'h1);

    // Streaming 0x1..0x8 with out_ready held high
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(i);
      tick();
      chk_out($sformatf("stream%0d", i), 1'b1, W'(i), 1'b1, 0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk_out("stream.drain", 1'b0, RV, 1'b1, 0);

    // Backpressure: A, B accepted, C held off
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h000A;
    tick();
    chk_out("bp.A", 1'b1, 16'h000A, 1'b1, 0);
    bus.in_data = 16'h000B;
    tick();
    exp_stall = 1;
    chk_out("bp.B", 1'b1, 16'h000A, 1'b0, exp_stall);
    bus.in_data = 16'h000C;
    tick();
    exp_stall = 2;
    chk_out("bp.C_wait", 1'b1, 16'h000A, 1'b0, exp_stall);
    bus.out_ready = 1'b1;
    tick();
    chk_out("bp.deqA", 1'b1, 16'h000B, 1'b1, exp_stall);
    tick();
    chk_out("bp.deqB", 1'b1, 16'h000C, 1'b1, exp_stall);
    bus.in_valid = 1'b0;
    tick();
    chk_out("bp.deqC", 1'b0, RV, 1'b1, exp_stall);

    // Flush from FULL with a competing offer of 0xD
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h000A;
    tick();
    bus.in_data = 16'h000B;
    tick();
    exp_stall = 3;
    chk_out("fl.full", 1'b1, 16'h000A, 1'b0, exp_stall);
    bus.flush   = 1'b1;
    bus.in_data = 16'h000D;
    tick();
    exp_stall = 4;
    chk_out("fl.flushed", 1'b0, RV, 1'b1, exp_stall);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk_out("fl.noD", 1'b0, RV, 1'b1, exp_stall);

    // Flush from BUSY while in_ready=1: the offered beat must be dropped
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h000A;
    tick();
    bus.flush   = 1'b1;
    bus.in_data = 16'h000E;
    tick();
    exp_stall = 5;
    chk_out("flb.flushed", 1'b0, RV, 1'b1, exp_stall);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk_out("flb.noE", 1'b0, RV, 1'b1, exp_stall);
    chk("flb.stall4", 32'(bus4.stall_count), 32'h5);

    // Saturation: hold one beat stalled for 20 cycles
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0055;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    exp_stall = 25;
    chk_out("sat.hold", 1'b1, 16'h0055, 1'b1, exp_stall);
    chk("sat.stall4", 32'(bus4.stall_count), 32'hF);

    // Fill to FULL, then async reset between edges
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0066;
    tick();
    exp_stall = 26;
    chk_out("ar.full", 1'b1, 16'h0055, 1'b0, exp_stall);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_out("ar.async", 1'b0, RV, 1'b0, 0);
    chk("ar.stall4", 32'(bus4.stall_count), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk_out("ar.release", 1'b0, RV, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WIDTH, default 64, payload width in bits (e.g. {PC, INSTR}).
REQ-002 Parameter RESET_VALUE, default {WIDTH{1'b0}}, bubble/NOP payload.
REQ-003 Parameter CNT_WIDTH, default 16, width of the stall counter.
REQ-004 One clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  upstream offers in_data this cycle.
REQ-008 in_ready  output  1  stage accepts in_data this cycle; driven directly from a register.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid beat.
REQ-011 out_ready  input  1  downstream takes out_data this cycle.
REQ-012 out_data  output  WIDTH  payload to the next stage.
REQ-013 flush  input  1  synchronous squash of all held beats (branch/jump redirect).
REQ-014 stall_count  output  CNT_WIDTH  cycles with out_valid=1 and out_ready=0.

Function
REQ-015 The block SHALL hold up to two beats in a main register (drives out_data) and a skid register, tracked by state EMPTY, BUSY (main only) or FULL (main+skid).
REQ-016 Accept = in_valid & in_ready; take = out_valid & out_ready; both are evaluated at the rising edge.
REQ-017 in_ready SHALL equal (state != FULL), registered, with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (state != EMPTY).
REQ-019 EMPTY: accept -> BUSY, main <= in_data; otherwise stay.
REQ-020 BUSY: accept & take -> BUSY, main <= in_data; accept & !take -> FULL, skid <= in_data; !accept & take -> EMPTY; otherwise hold.
REQ-021 FULL: take -> BUSY, main <= skid; !take -> hold; no accept is possible.
REQ-022 Latency: a beat accepted in EMPTY SHALL appear on out_data with out_valid=1 in the following cycle.
REQ-023 Beats SHALL leave in acceptance order; none is dropped or duplicated except by flush.
REQ-024 out_data SHALL equal RESET_VALUE whenever out_valid=0, so main is reloaded with RESET_VALUE on every entry to EMPTY.
REQ-025 Flush SHALL have highest priority: next state EMPTY, main and skid <= RESET_VALUE, and any beat accepted in the same cycle is discarded.
REQ-026 A take coinciding with flush SHALL count as delivered; the held beats are squashed.
REQ-027 stall_count SHALL increment by 1 each cycle with out_valid & !out_ready, saturate at all-ones, and be unaffected by flush.
REQ-028 Full throughput: with out_ready held at 1, the stage SHALL sustain one beat per cycle.

Reset
REQ-029 While reset=1: state=EMPTY, main=skid=RESET_VALUE, stall_count=0, out_valid=0, out_data=RESET_VALUE.
REQ-030 While reset=1: in_ready=0. It SHALL rise to 1 on the first clock edge after reset deasserts.
REQ-031 Reset asserted mid-operation (any state) SHALL discard all beats immediately, without waiting for a clock edge.

Verification
REQ-032 Streaming: out_ready=1; send 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later, out_valid held 1, stall_count=0.
REQ-033 Backpressure: out_ready=0; offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, in_ready=0 from the cycle after 0xB, and stall_count increments every cycle. Then out_ready=1 -> 0xA, 0xB, 0xC delivered in order.
REQ-034 Flush: in FULL (0xA, 0xB), assert flush with in_valid=1 and in_data=0xD -> next cycle out_valid=0, out_data=RESET_VALUE, in_ready=1, 0xD never appears.
REQ-035 Saturation: CNT_WIDTH=4, out_valid=1, out_ready=0 for 20 cycles -> stall_count stops at 0xF.
REQ-036 Async reset: assert reset between edges while in FULL -> out_valid=0 and stall_count=0 before the next edge, and in_ready=1 one edge after release.
